// File: rtl/mod_mapper_pp_if.sv
// Bit-stream input, block control and symbol-RAM write bus of the modulation mapper.
// The mapper sits on the slave modport; the bit source, consumer and RAM sit on master.
interface mod_mapper_pp_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 11
);
    // Bit_In is transferred on every rising clock edge where Bit_Valid and Bit_Ready are
    // both high. Bit_Valid never waits for Bit_Ready. Mod_Valid_OUT has no back-channel:
    // it is a one-cycle RAM write strobe qualifying Mod_OUT_I/Q, Wr_addr and Wr_bank.
    logic                     Bit_In;
    logic                     Bit_Valid;
    logic                     Bit_Ready;
    logic [3:0]               Order_Mod;
    logic [ADDR_W-1:0]        Num_Syms;
    logic                     Flush;
    logic [1:0]               Bank_Release;
    logic signed [DATA_W-1:0] Mod_OUT_I;
    logic signed [DATA_W-1:0] Mod_OUT_Q;
    logic                     Mod_Valid_OUT;
    logic [ADDR_W-1:0]        Wr_addr;
    logic                     Wr_bank;
    logic                     Block_Done;
    logic [ADDR_W-1:0]        Last_addr;
    logic                     Cfg_Err;
    logic [1:0]               dbg_state;

    modport master (
        output Bit_In, Bit_Valid, Order_Mod, Num_Syms, Flush, Bank_Release,
        input  Bit_Ready, Mod_OUT_I, Mod_OUT_Q, Mod_Valid_OUT, Wr_addr, Wr_bank,
               Block_Done, Last_addr, Cfg_Err, dbg_state
    );

    modport slave (
        input  Bit_In, Bit_Valid, Order_Mod, Num_Syms, Flush, Bank_Release,
        output Bit_Ready, Mod_OUT_I, Mod_OUT_Q, Mod_Valid_OUT, Wr_addr, Wr_bank,
               Block_Done, Last_addr, Cfg_Err, dbg_state
    );
endinterface

// File: rtl/mod_mapper_pp.sv
// Serial-bit to Gray-mapped QPSK/16QAM/64QAM symbol mapper writing a ping-pong symbol RAM.
// Define MOD_QAM256_EN to add the 256QAM datapath (Order_Mod=8).
module mod_mapper_pp #(
    parameter int DATA_W    = 18,
    parameter int ADDR_W    = 11,
    parameter int MAX_SYMS  = 1200,
    parameter int SC_QPSK   = 724,
    parameter int SC_QAM16  = 324,
    parameter int SC_QAM64  = 158
`ifdef MOD_QAM256_EN
    , parameter int SC_QAM256 = 79
`endif
) (
    input logic             CLK_Mod,
    input logic             RST_Mod,
    mod_mapper_pp_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_CLOSE = 2'd2, S_STALL = 2'd3} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d, ord_q, ord_d;
    logic [7:0]               sym_q, sym_d;
    logic [ADDR_W-1:0]        num_q, num_d, addr_q, addr_d, wa_q, wa_d, last_q, last_d;
    logic                     new_blk_q, new_blk_d, bank_q, bank_d;
    logic [1:0]               full_q, full_d;
    logic signed [DATA_W-1:0] i_q, i_d, q_q, q_d;
    logic                     vld_q, vld_d, done_q, done_d, err_q, err_d, rdy_q, rdy_d;
    logic                     accept, legal_now, complete, flush_ok;
    logic [3:0]               ord_now;

    function automatic logic is_legal(input logic [3:0] o);
        case (o)
            4'd2, 4'd4, 4'd6: return 1'b1;
`ifdef MOD_QAM256_EN
            4'd8:             return 1'b1;
`endif
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic signed [4:0] sgn(input logic b);
        return b ? -5'sd1 : 5'sd1;
    endfunction

    // b holds the four bits of one axis, b[0] being the most significant (sign) bit.
    function automatic logic signed [4:0] level(input logic [3:0] b, input logic [3:0] ord);
        logic signed [4:0] mag;
        case (ord)
            4'd4:    mag = 5'sd2 - sgn(b[1]);
            4'd6:    mag = 5'sd4 - sgn(b[1]) * (5'sd2 - sgn(b[2]));
`ifdef MOD_QAM256_EN
            4'd8:    mag = 5'sd8 - sgn(b[1]) * (5'sd4 - sgn(b[2]) * (5'sd2 - sgn(b[3])));
`endif
            default: mag = 5'sd1;
        endcase
        return sgn(b[0]) * mag;
    endfunction

    function automatic logic signed [DATA_W-1:0] scaled(input logic signed [4:0] l,
                                                        input logic [3:0] ord);
        logic signed [DATA_W-1:0] sc, lx;
        case (ord)
            4'd4:    sc = DATA_W'(SC_QAM16);
            4'd6:    sc = DATA_W'(SC_QAM64);
`ifdef MOD_QAM256_EN
            4'd8:    sc = DATA_W'(SC_QAM256);
`endif
            default: sc = DATA_W'(SC_QPSK);
        endcase
        lx = {{(DATA_W-5){l[4]}}, l};
        return lx * sc;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sym_d     = sym_q;
        ord_d     = ord_q;
        num_d     = num_q;
        addr_d    = addr_q;
        new_blk_d = new_blk_q;
        bank_d    = bank_q;
        i_d       = i_q;
        q_d       = q_q;
        vld_d     = 1'b0;
        wa_d      = wa_q;
        done_d    = 1'b0;
        last_d    = last_q;
        err_d     = err_q;
        accept    = bus.Bit_Valid & rdy_q;
        ord_now   = new_blk_q ? bus.Order_Mod : ord_q;
        legal_now = is_legal(ord_now);
        complete  = 1'b0;
        flush_ok  = 1'b0;
        full_d    = full_q & ~bus.Bank_Release;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    state_d = S_RUN;
                    if (new_blk_q) begin
                        new_blk_d = 1'b0;
                        ord_d     = bus.Order_Mod;
                        num_d     = (bus.Num_Syms == '0 || bus.Num_Syms > ADDR_W'(MAX_SYMS)) ?
                                    ADDR_W'(MAX_SYMS) : bus.Num_Syms;
                        if (!legal_now) err_d = 1'b1;
                    end
                    // An illegal order still consumes bits but never assembles a symbol.
                    if (legal_now) begin
                        sym_d[cnt_q[2:0]] = bus.Bit_In;
                        if (cnt_q + 4'd1 == ord_now) begin
                            complete = 1'b1;
                            cnt_d    = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                if (complete) begin
                    i_d    = scaled(level({sym_d[6], sym_d[4], sym_d[2], sym_d[0]}, ord_now), ord_now);
                    q_d    = scaled(level({sym_d[7], sym_d[5], sym_d[3], sym_d[1]}, ord_now), ord_now);
                    vld_d  = 1'b1;
                    wa_d   = addr_q;
                    addr_d = addr_q + ADDR_W'(1);
                end
                flush_ok = (state_q == S_RUN) && bus.Flush && (addr_q != '0 || complete);
                // The final write and the Block_Done pulse share the CLOSE cycle.
                if ((complete && addr_q == num_q - ADDR_W'(1)) || flush_ok) begin
                    state_d   = S_CLOSE;
                    done_d    = 1'b1;
                    last_d    = complete ? addr_q : addr_q - ADDR_W'(1);
                    addr_d    = '0;
                    cnt_d     = 4'd0;
                    new_blk_d = 1'b1;
                end
            end
            S_CLOSE: begin
                full_d[bank_q] = 1'b1;
                bank_d         = ~bank_q;
                wa_d           = '0;
                state_d        = (full_q[~bank_q] && !bus.Bank_Release[~bank_q]) ? S_STALL : S_RUN;
            end
            S_STALL: begin
                if (bus.Bank_Release[bank_q]) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        rdy_d = (state_d == S_IDLE) || (state_d == S_RUN);
    end

    always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
        if (!RST_Mod) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sym_q     <= '0;
            ord_q     <= '0;
            num_q     <= '0;
            addr_q    <= '0;
            new_blk_q <= 1'b1;
            bank_q    <= 1'b0;
            full_q    <= '0;
            i_q       <= '0;
            q_q       <= '0;
            vld_q     <= 1'b0;
            wa_q      <= '0;
            done_q    <= 1'b0;
            last_q    <= '0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sym_q     <= sym_d;
            ord_q     <= ord_d;
            num_q     <= num_d;
            addr_q    <= addr_d;
            new_blk_q <= new_blk_d;
            bank_q    <= bank_d;
            full_q    <= full_d;
            i_q       <= i_d;
            q_q       <= q_d;
            vld_q     <= vld_d;
            wa_q      <= wa_d;
            done_q    <= done_d;
            last_q    <= last_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
        end
    end

    assign bus.Bit_Ready     = rdy_q;
    assign bus.Mod_OUT_I     = i_q;
    assign bus.Mod_OUT_Q     = q_q;
    assign bus.Mod_Valid_OUT = vld_q;
    assign bus.Wr_addr       = wa_q;
    assign bus.Wr_bank       = bank_q;
    assign bus.Block_Done    = done_q;
    assign bus.Last_addr     = last_q;
    assign bus.Cfg_Err       = err_q;
    assign bus.dbg_state     = state_q;
endmodule
